poly_pitch2dds: RTL and testbench
=================================

# poly_pitch2dds

Parametrised, time-multiplexed successor to the single-voice note/pitch-wheel to DDS converter. It converts `VOICES` MIDI note numbers plus one shared 14-bit pitch-wheel value into per-voice 32-bit DDS phase increments. It supports a run-time bend range and uses exact linear interpolation between semitone table entries. The block sits between the MIDI voice allocator and the DDS oscillator bank, and it shares one `note2dds` table instance across all voices.

## Interface
- `VOICES`, 8 — number of voices; must be ≥1 and ≤32.
- `IDXW`, 3 — width of the voice index, equal to ceil(log2(`VOICES`)), minimum 1.
- `CLK` in 1 — single clock; every register is clocked on the rising edge.
- `RESET` in 1 — asynchronous, active-high reset.
- `NOTE_BUS` in 7*`VOICES` — voice v's note is bits [7v+6:7v].
- `PITCH` in 14 — pitch wheel; 8192 means centre (no bend).
- `RANGE` in 4 — bend range in semitones at full wheel deflection. Values 0..12 are used as given; 13..15 are treated as 12.
- `ADDER_BUS` out 32*`VOICES` — voice v's phase increment is bits [32v+31:32v]; the outputs are registered.
- `UPD_STB` out 1 — one-cycle pulse when a voice's output is written.
- `UPD_IDX` out `IDXW` — the voice written during `UPD_STB`.
- `BUSY` out 1 — high in every state except SCAN.

## Operation
- Per-voice snapshot registers hold `note_s[v]` (7 b), `pitch_s[v]` (14 b), `range_s[v]` (4 b, already clamped) and `valid[v]`.
- Dirty flag: `dirty[v]` = !`valid[v]`, or the current `NOTE` differs from `note_s[v]`, or `PITCH` differs from `pitch_s[v]`, or the clamped `RANGE` differs from `range_s[v]`.
- Scheduler: round-robin pointer `rr`. In SCAN, pick the first dirty voice at or after `rr`, wrapping at `VOICES`-1 back to 0.
  - If no voice is dirty, stay in SCAN.
  - Otherwise, in the same cycle: copy the current inputs into that voice's snapshot, set `valid`=1, latch the index into `cur`, and set `rr`=`cur`+1 (wrapping).
- Arithmetic, using only the snapshot of `cur`:
  - `c` = `pitch_s` − 8192, signed 15 b (−8192..8191).
  - `b` = (`c` * `range_s`) >>> 5, signed; this is bend in 1/256-semitone units, ±3072 maximum, floored.
  - `hi` = `b` >>> 8 (signed, −12..11); `lo` = `b`[7:0] (unsigned).
  - `n` = `note_s` + `hi`, signed 9 b.
  - `n0` = clamp(`n`, 0, 127); `n1` = clamp(`n`+1, 0, 127).
  - Result = (T[n0]·(256−`lo`) + T[n1]·`lo`) >> 8, using a 41-bit accumulator; take the low 32 b.
  - Weights sum to 256, so `lo`=0 gives exactly T[n0], and a clamped pair gives exactly T[127] or T[0].
- Table: the shared `note2dds` instance provides T[n]. It has a 7-bit address and returns a 32-bit value registered one cycle after the address is presented.
- FSM states:
  - SCAN: described above. Go to FETCH0 when a voice is picked.
  - FETCH0: present `n0`; clear the accumulator.
  - FETCH1: present `n1`; accumulator += T[n0]·(256−`lo`).
  - ACC: accumulator += T[n1]·`lo`.
  - STORE: write `ADDER_BUS[cur]` = accumulator >> 8; pulse `UPD_STB` with `UPD_IDX`=`cur`; return to SCAN.
- Input changes during a job are not applied to that job. They make the voice dirty again, and it is re-serviced on a later scan.
- Once a job leaves SCAN it always completes; only `RESET` aborts it.

## Timing
- Reset values:
  - `ADDER_BUS`=0, `UPD_STB`=0, `UPD_IDX`=0, `BUSY`=0.
  - FSM in SCAN, `rr`=0, all `valid`=0, all snapshots 0.
  - The accumulator is cleared.
- Reset asserted mid-job: the job is abandoned immediately and no `UPD_STB` is issued. After release, all voices are recomputed from voice 0 upward.
- Each voice job takes 5 cycles (SCAN, FETCH0, FETCH1, ACC, STORE), and jobs run back-to-back.
- An input change sampled at SCAN edge t updates `ADDER_BUS` and pulses `UPD_STB` on edge t+4. For a voice waiting behind k other jobs, the worst case is 5·(k+1) cycles.
- A `PITCH` or `RANGE` change dirties all voices. A full refresh takes 5·`VOICES` cycles (40 at the default), in round-robin order starting from `rr`.
- `ADDER_BUS` is written only in STORE. All other voices' outputs hold their values, so glitch-free values are always presented.

## Test plan
- Reset release with all notes 69, `PITCH`=8192, `RANGE`=2:
  - `UPD_STB` fires for voices 0..7 in order, every 5 cycles.
  - Each `ADDER_BUS` slot = T[69]; `BUSY` drops after 40 cycles.
- Voice 3 note changed to 60 while idle:
  - Exactly one job runs; `UPD_IDX`=3 on edge t+4; slot 3 = T[60].
  - All other slots are unchanged.
- `PITCH`=16383, `RANGE`=2, note 69: `b`=511, `hi`=1, `lo`=255, so the slot = (T[70]·1 + T[71]·255)>>8.
- `PITCH`=0, `RANGE`=2, note 69 gives exactly T[67].
- `PITCH`=4096, `RANGE`=12, note 69 (`b`=−1536) gives exactly T[63].
- Clamping: note 127, `PITCH`=16383, `RANGE`=15 (treated as 12) gives exactly T[127]. Note 0, `PITCH`=0, `RANGE`=12 gives exactly T[0].
- Mid-job update: change voice 2's note from 40 to 41 during its FETCH1.
  - The first `UPD_STB` for voice 2 carries T[40].
  - A second job follows and gives T[41].
  - Asserting `RESET` during ACC produces no strobe, and all `ADDER_BUS` slots read 0.

Source files
------------

// File: rtl/poly_pitch2dds.sv
// poly_pitch2dds: time-multiplexed note + pitch-wheel to DDS phase increment
// converter. One shared note2dds table serves all voices. A round-robin
// scheduler picks dirty voices, and a 5-cycle job computes and stores each
// voice's result. The job interpolates linearly between adjacent semitones.

// note2dds: semitone table with a registered output.
// T[n] = BASE[n mod 12] >> (10 - n div 12), where BASE holds octave 10 (MIDI
// 120..131) as DDS increments for a 50 MHz clock and a 32-bit phase
// accumulator.
module note2dds (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [6:0]  addr,
  output logic [31:0] data
);

  logic [3:0]  octave;
  logic [3:0]  semi;
  logic [31:0] base;

  // Split the note into octave and semitone, then look up the top-octave value.
  always_comb begin
    octave = 4'(addr / 7'd12);
    semi   = 4'(addr % 7'd12);
    case (semi)
      4'd0:    base = 32'd719151;
      4'd1:    base = 32'd761914;
      4'd2:    base = 32'd807220;
      4'd3:    base = 32'd855219;
      4'd4:    base = 32'd906073;
      4'd5:    base = 32'd959951;
      4'd6:    base = 32'd1017033;
      4'd7:    base = 32'd1077509;
      4'd8:    base = 32'd1141581;
      4'd9:    base = 32'd1209463;
      4'd10:   base = 32'd1281381;
      default: base = 32'd1357577;
    endcase
  end

  // Register the value one cycle after the address is presented.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) data <= '0;
    else       data <= base >> (4'd10 - octave);
  end

endmodule

module poly_pitch2dds #(
  parameter int VOICES = 8,
  parameter int IDXW   = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [7*VOICES-1:0]    NOTE_BUS,
  input  logic [13:0]            PITCH,
  input  logic [3:0]             RANGE,
  output logic [32*VOICES-1:0]   ADDER_BUS,
  output logic                   UPD_STB,
  output logic [IDXW-1:0]        UPD_IDX,
  output logic                   BUSY
);

  typedef enum logic [2:0] {SCAN, FETCH0, FETCH1, ACC, STORE} state_t;

  state_t state, next_state;

  logic [6:0]  note_s  [VOICES];
  logic [13:0] pitch_s [VOICES];
  logic [3:0]  range_s [VOICES];
  logic [VOICES-1:0] valid;

  logic [6:0]  note_in [VOICES];
  logic [3:0]  range_c;
  logic [VOICES-1:0] dirty;
  logic            found;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] rr;
  logic [IDXW-1:0] cur;
  logic [IDXW-1:0] cur_next;

  logic signed [14:0] c;
  logic signed [19:0] prod;
  logic signed [12:0] b;
  logic signed [8:0]  hi;
  logic [7:0]         lo;
  logic signed [8:0]  n;
  logic signed [8:0]  n_p1;
  logic [6:0]         n0;
  logic [6:0]         n1;
  logic [6:0]         tab_addr;
  logic [31:0]        tab_data;
  logic [8:0]         w0;
  logic [8:0]         w1;
  logic [40:0]        acc;
  logic [32*VOICES-1:0] adder_q;

  // Unpack the note bus, clamp the range, and flag voices whose snapshot is stale.
  // NOTE: every variable written here gets a default before any conditional use; otherwise a latch is inferred.
  always_comb begin
    range_c = (RANGE > 4'd12) ? 4'd12 : RANGE;
    for (int v = 0; v < VOICES; v++) begin
      note_in[v] = NOTE_BUS[7*v +: 7];
      dirty[v]   = !valid[v] || (note_in[v] != note_s[v]) ||
                   (PITCH != pitch_s[v]) || (range_c != range_s[v]);
    end
  end

  // Round-robin pick: first dirty voice at or after rr, wrapping.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < VOICES; k++) begin
      if (!found && dirty[IDXW'((int'(rr) + k) % VOICES)]) begin
        found    = 1'b1;
        pick_idx = IDXW'((int'(rr) + k) % VOICES);
      end
    end
    cur_next = (pick_idx == IDXW'(VOICES - 1)) ? '0 : pick_idx + 1'b1;
  end

  // Next-state logic for the job sequencer.
  always_comb begin
    next_state = state;
    case (state)
      SCAN:    if (found) next_state = FETCH0;
      FETCH0:  next_state = FETCH1;
      FETCH1:  next_state = ACC;
      ACC:     next_state = STORE;
      STORE:   next_state = SCAN;
      default: next_state = SCAN;
    endcase
  end

  // Bend arithmetic from the current voice's snapshot only.
  always_comb begin
    c    = $signed({1'b0, pitch_s[cur]}) - 15'sd8192;
    prod = 20'(c) * 20'($signed({1'b0, range_s[cur]}));
    b    = 13'(prod >>> 5);
    hi   = {{4{b[12]}}, b[12:8]};
    lo   = b[7:0];
    n    = $signed({2'b00, note_s[cur]}) + hi;
    n_p1 = n + 9'sd1;
    n0   = n[8]    ? 7'd0 : (n[7]    ? 7'd127 : n[6:0]);
    n1   = n_p1[8] ? 7'd0 : (n_p1[7] ? 7'd127 : n_p1[6:0]);
    w1   = {1'b0, lo};
    w0   = 9'd256 - w1;
    tab_addr = (state == FETCH1) ? n1 : n0;
  end

  note2dds u_table (
    .CLK   (CLK),
    .RESET (RESET),
    .addr  (tab_addr),
    .data  (tab_data)
  );

  // State register, scheduler pointer, and per-voice snapshots.
  // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
  // NOTE: the snapshot arrays are reset because their zero state is part of the defined post-reset behaviour.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= SCAN;
      rr    <= '0;
      cur   <= '0;
      valid <= '0;
      for (int v = 0; v < VOICES; v++) begin
        note_s[v]  <= '0;
        pitch_s[v] <= '0;
        range_s[v] <= '0;
      end
    end else begin
      state <= next_state;
      if (state == SCAN && found) begin
        note_s[pick_idx]  <= note_in[pick_idx];
        pitch_s[pick_idx] <= PITCH;
        range_s[pick_idx] <= range_c;
        valid[pick_idx]   <= 1'b1;
        cur               <= pick_idx;
        rr                <= cur_next;
      end
    end
  end

  // Accumulate the two weighted table reads, then publish the result.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc     <= '0;
      adder_q <= '0;
      UPD_STB <= 1'b0;
      UPD_IDX <= '0;
    end else begin
      UPD_STB <= 1'b0;
      case (state)
        FETCH0: acc <= '0;
        FETCH1: acc <= acc + 41'(tab_data) * 41'(w0);
        ACC:    acc <= acc + 41'(tab_data) * 41'(w1);
        STORE: begin
          adder_q[32*cur +: 32] <= acc[39:8];
          UPD_STB <= 1'b1;
          UPD_IDX <= cur;
        end
        default: ;
      endcase
    end
  end

  assign ADDER_BUS = adder_q;
  assign BUSY      = (state != SCAN);

endmodule

// File: tb/tb_poly_pitch2dds.sv
// Directed bench for poly_pitch2dds. Expected strobes are pushed to a
// scoreboard when stimulus is driven and popped when UPD_STB is seen.
module tb_poly_pitch2dds;

  localparam int V = 8;
  localparam logic [31:0] BASE [12] = '{
    32'd719151, 32'd761914, 32'd807220, 32'd855219, 32'd906073, 32'd959951,
    32'd1017033, 32'd1077509, 32'd1141581, 32'd1209463, 32'd1281381, 32'd1357577};

  logic              CLK = 1'b0;
  logic              RESET;
  logic [7*V-1:0]    NOTE_BUS;
  logic [13:0]       PITCH;
  logic [3:0]        RANGE;
  logic [32*V-1:0]   ADDER_BUS;
  logic              UPD_STB;
  logic [2:0]        UPD_IDX;
  logic              BUSY;

  poly_pitch2dds #(.VOICES(V), .IDXW(3)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .NOTE_BUS  (NOTE_BUS),
    .PITCH     (PITCH),
    .RANGE     (RANGE),
    .ADDER_BUS (ADDER_BUS),
    .UPD_STB   (UPD_STB),
    .UPD_IDX   (UPD_IDX),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int idx; logic [31:0] val; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_slot [V];
  int notes [V];
  int rr_m;
  int stb_cnt, first_stb, last_stb;
  int p;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] t_of(input int n);
    return BASE[n % 12] >> (10 - n / 12);
  endfunction

  function automatic int clamp7(input int n);
    return (n < 0) ? 0 : ((n > 127) ? 127 : n);
  endfunction

  function automatic logic [31:0] model(input int note, input int pitch, input int rng);
    int r, c, b, hi, lo, n0, n1;
    longint sum;
    r   = (rng > 12) ? 12 : rng;
    c   = pitch - 8192;
    b   = (c * r) >>> 5;
    hi  = b >>> 8;
    lo  = b & 255;
    n0  = clamp7(note + hi);
    n1  = clamp7(note + hi + 1);
    sum = longint'(t_of(n0)) * (256 - lo) + longint'(t_of(n1)) * lo;
    return 32'(sum >> 8);
  endfunction

  function automatic logic [31:0] slot(input int v);
    return ADDER_BUS[32*v +: 32];
  endfunction

  task automatic apply();
    for (int v = 0; v < V; v++) NOTE_BUS[7*v +: 7] = 7'(notes[v]);
  endtask

  task automatic push(input int v);
    exp_t e;
    e.idx = v;
    e.val = model(notes[v], int'(PITCH), int'(RANGE));
    sb.push_back(e);
    exp_slot[v] = e.val;
    rr_m = (v + 1) % V;
  endtask

  task automatic push_all();
    int start;
    start = rr_m;
    for (int k = 0; k < V; k++) push((start + k) % V);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    @(negedge CLK);
    while ((sb.size() != 0 || BUSY) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("drain_left", sb.size(), 0);
    check("drain_busy", BUSY, 0);
  endtask

  task automatic check_slots(input string tag);
    for (int v = 0; v < V; v++) check(tag, slot(v), exp_slot[v]);
  endtask

  // Strobe monitor: pops the scoreboard and checks index and value.
  always @(negedge CLK) begin
    if (UPD_STB === 1'b1) begin
      if (stb_cnt == 0) first_stb = cyc;
      last_stb = cyc;
      stb_cnt++;
      if (sb.size() == 0) begin
        check("spurious_stb", UPD_STB, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("stb_idx", UPD_IDX, e.idx);
        check("stb_val", slot(e.idx), e.val);
      end
    end
  end

  initial begin
    stb_cnt = 0;
    RESET = 1'b1;
    for (int v = 0; v < V; v++) begin
      notes[v] = 69;
      exp_slot[v] = '0;
    end
    PITCH = 14'd8192;
    RANGE = 4'd2;
    apply();
    rr_m = 0;
    repeat (3) @(negedge CLK);
    check("rst_bus", |ADDER_BUS, 0);
    check("rst_stb", UPD_STB, 0);
    check("rst_idx", UPD_IDX, 0);
    check("rst_busy", BUSY, 0);

    // Reset release: voices 0..7 in order, every 5 cycles.
    stb_cnt = 0;
    push_all();
    p = cyc;
    RESET = 1'b0;
    drain(100);
    check("init_count", stb_cnt, 8);
    check("init_first", first_stb, p + 5);
    check("init_span", last_stb - first_stb, 35);
    check_slots("init_slot");
    check("init_t69", slot(7), t_of(69));

    // Single note change while idle.
    stb_cnt = 0;
    notes[3] = 60;
    apply();
    push(3);
    p = cyc;
    drain(50);
    repeat (10) @(negedge CLK);
    check("v3_count", stb_cnt, 1);
    check("v3_latency", first_stb, p + 5);
    check("v3_t60", slot(3), t_of(60));
    check_slots("v3_slot");

    // Full bend up: interpolated between T[70] and T[71].
    stb_cnt = 0;
    PITCH = 14'd16383;
    push_all();
    drain(100);
    check("up_count", stb_cnt, 8);
    check("up_v0", slot(0), 32'((longint'(t_of(70)) + longint'(t_of(71)) * 255) >> 8));
    check_slots("up_slot");

    // Full bend down, range 2: exactly T[67].
    PITCH = 14'd0;
    push_all();
    drain(100);
    check("down_v0", slot(0), t_of(67));

    // Half bend down, range 12: exactly T[63].
    PITCH = 14'd4096;
    RANGE = 4'd12;
    push_all();
    drain(100);
    check("half_v0", slot(0), t_of(63));
    check_slots("half_slot");

    // Upper clamp with range 15 treated as 12.
    notes[0] = 127;
    apply();
    PITCH = 14'd16383;
    RANGE = 4'd15;
    push_all();
    drain(100);
    check("clamp_hi", slot(0), t_of(127));

    // Range 15 and 12 are equivalent, so no job should start.
    stb_cnt = 0;
    RANGE = 4'd12;
    repeat (20) @(negedge CLK);
    check("rng_eq_count", stb_cnt, 0);
    check("rng_eq_busy", BUSY, 0);

    // Lower clamp.
    notes[1] = 0;
    apply();
    PITCH = 14'd0;
    push_all();
    drain(100);
    check("clamp_lo", slot(1), t_of(0));
    check_slots("clamp_slot");

    // Back to centre, then a note change during FETCH1.
    PITCH = 14'd8192;
    RANGE = 4'd2;
    push_all();
    drain(100);
    stb_cnt = 0;
    notes[2] = 40;
    apply();
    push(2);
    p = cyc;
    repeat (2) @(negedge CLK);
    notes[2] = 41;
    apply();
    push(2);
    drain(50);
    check("mid_count", stb_cnt, 2);
    check("mid_first", first_stb, p + 5);
    check("mid_second", last_stb, p + 10);
    check("mid_t41", slot(2), t_of(41));

    // Reset during ACC: no strobe, everything zero, then a full refresh from voice 0.
    stb_cnt = 0;
    notes[5] = 50;
    apply();
    p = cyc;
    repeat (3) @(negedge CLK);
    check("acc_busy", BUSY, 1);
    RESET = 1'b1;
    #1;
    check("abort_stb", UPD_STB, 0);
    check("abort_bus", |ADDER_BUS, 0);
    check("abort_busy", BUSY, 0);
    repeat (3) @(negedge CLK);
    check("abort_count", stb_cnt, 0);
    rr_m = 0;
    push_all();
    p = cyc;
    RESET = 1'b0;
    drain(100);
    check("rec_count", stb_cnt, 8);
    check("rec_first", first_stb, p + 5);
    check_slots("rec_slot");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
